// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART enums, data-bits encoding and majority sample points
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } uart_parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_rx_state_t;

    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    localparam int MAJ_SAMPLE_LO  = 7;
    localparam int MAJ_SAMPLE_MID = 8;
    localparam int MAJ_SAMPLE_HI  = 9;

    // Code 2'b11 is a second encoding of "no parity".
    function automatic uart_parity_t decode_parity(input logic [1:0] code);
        case (code)
            2'b01:   return PAR_EVEN;
            2'b10:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

    function automatic logic [2:0] last_bit_index(input logic [1:0] code);
        case (code)
            DBITS_5: return 3'd4;
            DBITS_6: return 3'd5;
            DBITS_7: return 3'd6;
            DBITS_8: return 3'd7;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - oversample tick prescaler, one tick every i_div+1 clocks
module uart_baud_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_restart,
    input  logic [DIV_WIDTH-1:0] i_div,
    output logic                 o_tick
);

    logic [DIV_WIDTH-1:0] cnt;

    // >= so a divisor lowered below the running count wraps at once
    assign o_tick = (cnt >= i_div);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_restart) begin
            cnt <= '0;
        end else if (o_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 16x oversampled UART receiver; UART_RX_BREAK_DETECT_EN adds o_break
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int DIV_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic [DIV_WIDTH-1:0] i_baud_div,
    input  logic [1:0]           i_data_bits,
    input  logic [1:0]           i_parity,
    input  logic                 i_stop2,
    input  logic                 i_rx,
    output logic [7:0]           o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
`ifdef UART_RX_BREAK_DETECT_EN
    output logic                 o_break,
`endif
    output logic                 o_busy
);

    localparam int SCW = $clog2(OVERSAMPLE);
    localparam logic [SCW-1:0] S_LO   = SCW'(MAJ_SAMPLE_LO);
    localparam logic [SCW-1:0] S_MID  = SCW'(MAJ_SAMPLE_MID);
    localparam logic [SCW-1:0] S_HI   = SCW'(MAJ_SAMPLE_HI);
    localparam logic [SCW-1:0] S_LAST = SCW'(OVERSAMPLE - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s, rx_prev, fall, start, tick;
    uart_rx_state_t         state;
    logic [SCW-1:0]         scount;
    logic [2:0]             bit_idx, last_idx;
    logic                   samp0, samp1, maj;
    logic [7:0]             shreg;
    logic                   par_err_q, frm_err_q, ferr_final;
    uart_parity_t           par_lat;
    logic                   stop2_lat, last_stop, at_hi, at_end, deliver, brk;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q  <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], i_rx};
            rx_prev <= rx_s;
        end
    end

    assign rx_s       = sync_q[SYNC_STAGES-1];
    assign fall       = rx_prev & ~rx_s;
    assign start      = (state == IDLE) && i_en && fall;
    assign maj        = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);
    assign at_hi      = tick && (scount == S_HI);
    assign at_end     = tick && (scount == S_LAST);
    assign ferr_final = frm_err_q | ~maj;
    assign last_stop  = !stop2_lat || bit_idx[0];
    assign deliver    = i_en && (state == STOP) && at_hi && last_stop;

`ifdef UART_RX_BREAK_DETECT_EN
    assign brk = (shreg == 8'h00) && ferr_final;
`else
    assign brk = 1'b0;
`endif

    uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_restart (start),
        .i_div     (i_baud_div),
        .o_tick    (tick)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            o_busy    <= 1'b0;
            scount    <= '0;
            bit_idx   <= '0;
            last_idx  <= '0;
            samp0     <= 1'b0;
            samp1     <= 1'b0;
            shreg     <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            par_lat   <= PAR_NONE;
            stop2_lat <= 1'b0;
        end else if (!i_en) begin
            state  <= IDLE;
            o_busy <= 1'b0;
        end else begin
            if (tick && state != IDLE) begin
                scount <= scount + SCW'(1);
                if (scount == S_LO)  samp0 <= rx_s;
                if (scount == S_MID) samp1 <= rx_s;
            end
            case (state)
                IDLE: if (fall) begin
                    state     <= START;
                    o_busy    <= 1'b1;
                    scount    <= '0;
                    bit_idx   <= '0;
                    shreg     <= '0;
                    par_err_q <= 1'b0;
                    frm_err_q <= 1'b0;
                    last_idx  <= last_bit_index(i_data_bits);
                    par_lat   <= decode_parity(i_parity);
                    stop2_lat <= i_stop2;
                end
                START: if (at_hi && maj) begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end else if (at_end) begin
                    state <= DATA;
                end
                DATA: begin
                    if (at_hi) shreg[bit_idx] <= maj;
                    if (at_end) begin
                        if (bit_idx == last_idx) begin
                            bit_idx <= '0;
                            state   <= (par_lat == PAR_NONE) ? STOP : PARITY;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (at_hi) par_err_q <= maj ^ (^shreg) ^ (par_lat == PAR_ODD);
                    if (at_end) state <= STOP;
                end
                // Leave at the last stop decision so a following start edge is not missed.
                STOP: if (at_hi) begin
                    frm_err_q <= ferr_final;
                    if (last_stop) begin
                        scount <= '0;
                        if (brk) begin
                            state <= BREAK;
                        end else begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end
                    end
                end else if (at_end) begin
                    bit_idx <= bit_idx + 3'd1;
                end
                BREAK: if (!rx_s) begin
                    scount <= '0;
                end else if (at_end) begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (deliver && !brk) begin
                if (o_valid && !i_ready) begin
                    o_overrun <= 1'b1;
                end else begin
                    o_valid      <= 1'b1;
                    o_data       <= shreg;
                    o_parity_err <= par_err_q;
                    o_frame_err  <= ferr_final;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) o_break <= 1'b0;
        else       o_break <= deliver && brk;
    end
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - scoreboard bench for uart_rx_core; break checks under UART_RX_BREAK_DETECT_EN
module tb_uart_rx_core;

    localparam int OS = 16;

    logic        clk = 1'b0;
    logic        rst, en, ready, rx, stop2;
    logic [15:0] baud_div;
    logic [1:0]  data_bits, parity;
    logic [7:0]  data;
    logic        valid, perr, ferr, overrun, busy;
`ifdef UART_RX_BREAK_DETECT_EN
    logic        brk_o;
`endif

    uart_rx_core #(.OVERSAMPLE(OS), .DIV_WIDTH(16), .SYNC_STAGES(2)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_baud_div   (baud_div),
        .i_data_bits  (data_bits),
        .i_parity     (parity),
        .i_stop2      (stop2),
        .i_rx         (rx),
        .o_data       (data),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_parity_err (perr),
        .o_frame_err  (ferr),
        .o_overrun    (overrun),
`ifdef UART_RX_BREAK_DETECT_EN
        .o_break      (brk_o),
`endif
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0, checks = 0, cyc = 0;
    int   got_ovr = 0, exp_ovr = 0, got_brk = 0, exp_brk = 0;
    int   t_start = 0, t_valid = -1;
    bit   lat_arm = 1'b0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: parity counts ones over data+parity bit; frame error if any checked stop is 0.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] db, input logic [1:0] par,
                              input logic pb, input logic s1, input logic s2, input logic st2,
                              input bit expect_char, input bit scramble);
        int         nb      = 5 + int'(db);
        int         bt      = OS * (int'(baud_div) + 1);
        bit         has_par = (par == 2'b01) || (par == 2'b10);
        logic [7:0] md      = 8'(int'(d) % (1 << nb));
        int         ones    = $countones(md) + int'(pb);
        logic       e_perr  = has_par && ((ones % 2) != ((par == 2'b10) ? 1 : 0));
        logic       e_ferr  = !s1 || (st2 && !s2);
        bit         brk_frame = 1'b0;
        exp_t       e;
`ifdef UART_RX_BREAK_DETECT_EN
        brk_frame = (md == 8'h00) && e_ferr;
`endif
        if (expect_char && brk_frame) begin
            exp_brk++;
        end else if (expect_char) begin
            e.data = md; e.perr = e_perr; e.ferr = e_ferr;
            exp_q.push_back(e);
        end
        data_bits = db; parity = par; stop2 = st2;
        t_start = cyc;
        rx = 1'b0;
        wait_clk(bt);
        if (scramble) begin
            data_bits = 2'($urandom); parity = 2'($urandom); stop2 = 1'($urandom);
        end
        for (int i = 0; i < nb; i++) begin
            rx = d[i];
            wait_clk(bt);
        end
        if (has_par) begin rx = pb; wait_clk(bt); end
        rx = s1;
        wait_clk(bt);
        if (st2) begin rx = s2; wait_clk(bt); end
        rx = 1'b1;
        wait_clk(3 * bt);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (overrun) got_ovr++;
`ifdef UART_RX_BREAK_DETECT_EN
                if (brk_o) got_brk++;
`endif
                if (lat_arm && valid && !prev_valid) begin
                    t_valid = cyc;
                    lat_arm = 1'b0;
                end
                prev_valid = valid;
                if (valid && ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: got data 0x%0h, expected no character", data);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_data", 32'(data), 32'(e.data));
                        check("parity_err", 32'(perr), 32'(e.perr));
                        check("frame_err", 32'(ferr), 32'(e.ferr));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        int         lat;
        logic [7:0] d;
        logic [1:0] db, par;
        logic       pb, s1, s2, st2;

        rst = 1'b1; en = 1'b1; ready = 1'b1; rx = 1'b1;
        baud_div = 16'd3; data_bits = 2'b11; parity = 2'b00; stop2 = 1'b0;
        wait_clk(4);
        rst = 1'b0;
        @(negedge clk);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_data", 32'(data), 32'd0);
        check("reset_perr", 32'(perr), 32'd0);
        check("reset_ferr", 32'(ferr), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        wait_clk(1);

        // 8N1 0xA5 with latency window around 9.6 bit times
        lat_arm = 1'b1;
        send_frame(8'hA5, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        lat = t_valid - t_start;
        checks++;
        if (lat < 612 || lat > 626) begin
            errors++;
            $display("FAIL latency: got %0d clocks, expected 612..626", lat);
        end

        // 7E2 with wrong parity bit; 8N1 with low stop bit
        send_frame(8'h35, 2'b10, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        send_frame(8'h3C, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // overrun: second character dropped while first is held
        ready = 1'b0;
        send_frame(8'h11, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_ovr++;
        send_frame(8'h22, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("ovr_hold_valid", 32'(valid), 32'd1);
        check("ovr_hold_data", 32'(data), 32'h11);
        check("ovr_pulse_count", 32'(got_ovr), 32'(exp_ovr));
        wait_clk(1);
        ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("accept_clears_valid", 32'(valid), 32'd0);
        wait_clk(1);

        // false start: 5-tick low glitch
        rx = 1'b0;
        wait_clk(10);
        check("glitch_busy", 32'(busy), 32'd1);
        wait_clk(10);
        rx = 1'b1;
        wait_clk(60);
        check("false_start_idle", 32'(busy), 32'd0);

        // receiver disable drops a partial frame
        rx = 1'b0;
        wait_clk(100);
        check("partial_busy", 32'(busy), 32'd1);
        en = 1'b0;
        wait_clk(2);
        check("disable_idle", 32'(busy), 32'd0);
        rx = 1'b1;
        wait_clk(3 * 64);
        en = 1'b1;
        wait_clk(4);
        check("disable_no_valid", 32'(valid), 32'd0);

`ifdef UART_RX_BREAK_DETECT_EN
        rx = 1'b0;
        exp_brk++;
        wait_clk(20 * 64);
        check("break_no_valid", 32'(valid), 32'd0);
        rx = 1'b1;
        wait_clk(32);
        check("break_busy_hold", 32'(busy), 32'd1);
        wait_clk(64);
        check("break_busy_clear", 32'(busy), 32'd0);
`endif

        // randomized frames, config scrambled mid-frame to exercise the latch
        for (int n = 0; n < 24; n++) begin
            d   = 8'($urandom);
            db  = 2'($urandom);
            par = 2'($urandom);
            pb  = 1'($urandom);
            st2 = 1'($urandom);
            s1  = ($urandom_range(0, 5) != 0);
            s2  = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 5) == 0) begin
                d  = 8'h00;
                s1 = 1'b0;
            end
            baud_div = 16'($urandom_range(0, 3));
            send_frame(d, db, par, pb, s1, s2, st2, 1'b1, 1'b1);
        end

        for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("overrun_total", 32'(got_ovr), 32'(exp_ovr));
        check("break_total", 32'(got_brk), 32'(exp_brk));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
